// File: rtl/anita_nsector_trigger_processor_pkg.sv
// Shared types for the N-sector ANITA trigger front end.
// Mode and per-sector FSM encodings plus a popcount helper.
package anita_trig_pkg;

  typedef enum logic [1:0] {
    MODE_AND = 2'b00,
    MODE_OR  = 2'b01,
    MODE_LCP = 2'b10,
    MODE_RCP = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FIRE = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/anita_nsector_trigger_processor_if.sv
// Trigger-map side inputs and TURF side outputs of the trigger processor.
// master: drives lcp/rcp/mask/mode/window/ref/sel; slave: the processor.
interface anita_nsector_trigger_processor_if #(
  parameter int NSEC  = 6,
  parameter int WINW  = 4,
  parameter int SCALW = 16
);
  localparam int SELW = $clog2(NSEC);

  logic [NSEC-1:0]  lcp_i;
  logic [NSEC-1:0]  rcp_i;
  logic [NSEC-1:0]  mask_i;
  logic [1:0]       mode_i;
  logic [WINW-1:0]  window_i;
  logic             ref_pulse_i;
  logic [SELW-1:0]  scal_sel_i;
  logic [NSEC-1:0]  trig_o;
  logic             l2_o;
  logic [SCALW-1:0] scal_o;
  logic             scal_valid_o;

  modport master (
    output lcp_i, rcp_i, mask_i, mode_i,
    output window_i, ref_pulse_i, scal_sel_i,
    input  trig_o, l2_o, scal_o, scal_valid_o
  );

  modport slave (
    input  lcp_i, rcp_i, mask_i, mode_i,
    input  window_i, ref_pulse_i, scal_sel_i,
    output trig_o, l2_o, scal_o, scal_valid_o
  );

endinterface

// File: rtl/anita_nsector_trigger_processor_sector.sv
// One sector: LCP/RCP edge stretchers, mode/mask L1, fire/holdoff FSM, scaler.
// Ports: clk_i, rst_n_i, lcp, rcp, mask, mode, window, clr -> l1, trig, count.
module anita_sector_trigger
  import anita_trig_pkg::*;
#(
  parameter int WINW     = 4,
  parameter int TRIG_LEN = 4,
  parameter int HOLDOFF  = 8,
  parameter int SCALW    = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             lcp,
  input  logic             rcp,
  input  logic             mask,
  input  mode_e            mode,
  input  logic [WINW-1:0]  window,
  input  logic             clr,
  output logic             l1,
  output logic             trig,
  output logic [SCALW-1:0] count
);

  localparam int TMAX = (TRIG_LEN > HOLDOFF) ? TRIG_LEN : HOLDOFF;
  localparam int TW   = $clog2(TMAX + 1);

  logic [1:0]      cur;
  logic [1:0]      prev;
  logic [WINW-1:0] lcnt;
  logic [WINW-1:0] rcnt;
  logic [WINW-1:0] load;
  logic            ls;
  logic            rs;
  logic            l1_q;
  logic            l1_rise;
  logic            fire;
  state_e          state;
  state_e          state_n;
  logic [TW-1:0]   tmr;
  logic [TW-1:0]   tmr_n;

  assign load = (window == '0) ? WINW'(1) : window;
  assign ls   = (lcnt != '0);
  assign rs   = (rcnt != '0);

  // cur is the registered input, so rise is one cycle behind the pins
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cur  <= '0;
      prev <= '0;
      lcnt <= '0;
      rcnt <= '0;
      l1_q <= 1'b0;
    end else begin
      cur  <= {lcp, rcp};
      prev <= cur;
      l1_q <= l1;
      if (cur[1] & ~prev[1]) begin
        lcnt <= load;
      end else if (ls) begin
        lcnt <= lcnt - WINW'(1);
      end
      if (cur[0] & ~prev[0]) begin
        rcnt <= load;
      end else if (rs) begin
        rcnt <= rcnt - WINW'(1);
      end
    end
  end

  always_comb begin
    l1 = 1'b0;
    unique case (mode)
      MODE_AND: l1 = ls & rs;
      MODE_OR:  l1 = ls | rs;
      MODE_LCP: l1 = ls;
      MODE_RCP: l1 = rs;
      default:  l1 = 1'b0;
    endcase
    l1 = l1 & ~mask;
  end

  assign l1_rise = l1 & ~l1_q;
  assign fire    = (state == ST_IDLE) & l1_rise;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= ST_IDLE;
      tmr   <= '0;
    end else begin
      state <= state_n;
      tmr   <= tmr_n;
    end
  end

  always_comb begin
    state_n = state;
    tmr_n   = tmr;
    unique case (state)
      ST_IDLE: begin
        if (l1_rise) begin
          state_n = ST_FIRE;
          tmr_n   = TW'(TRIG_LEN - 1);
        end
      end
      ST_FIRE: begin
        if (tmr != '0) begin
          tmr_n = tmr - TW'(1);
        end else if (HOLDOFF == 0) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_HOLD;
          tmr_n   = TW'(HOLDOFF - 1);
        end
      end
      ST_HOLD: begin
        if (tmr != '0) begin
          tmr_n = tmr - TW'(1);
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
        tmr_n   = '0;
      end
    endcase
  end

  always_comb begin
    trig = (state == ST_FIRE);
  end

  // a fire coinciding with the bank clear opens the new period at 1
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count <= '0;
    end else if (clr) begin
      count <= {{(SCALW-1){1'b0}}, fire};
    end else if (fire && (count != '1)) begin
      count <= count + SCALW'(1);
    end
  end

endmodule

// File: rtl/anita_nsector_trigger_processor.sv
// NSEC-sector L1/L2 trigger processor with banked saturating scalers.
// Ports: clk_i, rst_n_i, bus (slave: lcp/rcp/mask/mode/window/ref/sel in; trig/l2/scal out).
module anita_nsector_trigger_processor
  import anita_trig_pkg::*;
#(
  parameter int NSEC     = 6,
  parameter int WINW     = 4,
  parameter int TRIG_LEN = 4,
  parameter int HOLDOFF  = 8,
  parameter int L2_N     = 2,
  parameter int SCALW    = 16
) (
  input logic clk_i,
  input logic rst_n_i,
  anita_nsector_trigger_processor_if.slave bus
);

  logic [NSEC-1:0]  l1;
  logic [NSEC-1:0]  trig;
  logic [SCALW-1:0] count [NSEC];
  logic [SCALW-1:0] bank  [NSEC];
  logic             ref_q;
  logic             ref_qq;
  logic             ref_rise;
  logic             valid_q;
  logic             valid_qq;
  logic             l2_lvl;
  logic             l2_lvl_q;
  logic             l2_lvl_qq;
  logic             l2_q;
  logic [SCALW-1:0] scal_q;

  for (genvar g = 0; g < NSEC; g++) begin : g_sec
    anita_sector_trigger #(
      .WINW    (WINW),
      .TRIG_LEN(TRIG_LEN),
      .HOLDOFF (HOLDOFF),
      .SCALW   (SCALW)
    ) u_sec (
      .clk_i  (clk_i),
      .rst_n_i(rst_n_i),
      .lcp    (bus.lcp_i[g]),
      .rcp    (bus.rcp_i[g]),
      .mask   (bus.mask_i[g]),
      .mode   (mode_e'(bus.mode_i)),
      .window (bus.window_i),
      .clr    (ref_rise),
      .l1     (l1[g]),
      .trig   (trig[g]),
      .count  (count[g])
    );
  end

  assign ref_rise = ref_q & ~ref_qq;
  assign l2_lvl   = int'(popcount(32'(l1))) >= L2_N;

  // l2 edge is taken on a registered level so it lands one cycle after trig
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ref_q     <= 1'b0;
      ref_qq    <= 1'b0;
      valid_q   <= 1'b0;
      valid_qq  <= 1'b0;
      l2_lvl_q  <= 1'b0;
      l2_lvl_qq <= 1'b0;
      l2_q      <= 1'b0;
      scal_q    <= '0;
    end else begin
      ref_q     <= bus.ref_pulse_i;
      ref_qq    <= ref_q;
      valid_q   <= ref_rise;
      valid_qq  <= valid_q;
      l2_lvl_q  <= l2_lvl;
      l2_lvl_qq <= l2_lvl_q;
      l2_q      <= l2_lvl_q & ~l2_lvl_qq;
      if (int'(bus.scal_sel_i) < NSEC) begin
        scal_q <= bank[bus.scal_sel_i];
      end else begin
        scal_q <= '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NSEC; i++) begin
        bank[i] <= '0;
      end
    end else if (ref_rise) begin
      for (int i = 0; i < NSEC; i++) begin
        bank[i] <= count[i];
      end
    end
  end

  // strobe delayed to line up with the registered read port
  assign bus.trig_o       = trig;
  assign bus.l2_o         = l2_q;
  assign bus.scal_o       = scal_q;
  assign bus.scal_valid_o = valid_qq;

endmodule

// File: tb/tb_anita_nsector_trigger_processor.sv
// Scoreboard bench for anita_nsector_trigger_processor.
// Expected trig/l2/scaler events are queued; a negedge monitor pops and checks.
module tb_anita_nsector_trigger_processor;

  localparam int NSEC  = 6;
  localparam int WINW  = 4;
  localparam int SCALW = 4;

  typedef enum int {EV_RISE, EV_FALL, EV_L2, EV_SCAL} ev_e;
  typedef struct {
    ev_e kind;
    int  cyc;
    int  val;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];
  logic [NSEC-1:0] trig_prev = '0;

  anita_nsector_trigger_processor_if #(
    .NSEC(NSEC), .WINW(WINW), .SCALW(SCALW)
  ) bus ();

  anita_nsector_trigger_processor #(
    .NSEC(NSEC), .WINW(WINW), .TRIG_LEN(4),
    .HOLDOFF(8), .L2_N(2), .SCALW(SCALW)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_ev(input ev_e kind, input int c, input int v);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  // trig rises d cycles after k and stays high for 4 cycles
  task automatic fire_exp(input int k, input int bits, input int d);
    expect_ev(EV_RISE, k + d, bits);
    expect_ev(EV_FALL, k + d + 4, bits);
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic got(input ev_e kind, input int v);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected %s at cycle %0d value 'h%0h, required none",
               kind.name(), cyc, v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.val != v) begin
        errors++;
        $display("FAIL event: got %s cycle %0d value 'h%0h, required %s cycle %0d value 'h%0h",
                 kind.name(), cyc, v, e.kind.name(), e.cyc, e.val);
      end
    end
  endtask

  always @(negedge clk) begin : mon
    logic [NSEC-1:0] r;
    logic [NSEC-1:0] f;
    r = bus.trig_o & ~trig_prev;
    f = ~bus.trig_o & trig_prev;
    if (rst_n) begin
      if (r != '0) got(EV_RISE, int'(r));
      if (f != '0) got(EV_FALL, int'(f));
      if (bus.l2_o) got(EV_L2, 1);
      if (bus.scal_valid_o) got(EV_SCAL, int'(bus.scal_o));
    end
    trig_prev = bus.trig_o;
  end

  task automatic pulse(input logic [NSEC-1:0] l, input logic [NSEC-1:0] r);
    bus.lcp_i = l;
    bus.rcp_i = r;
    step(1);
    bus.lcp_i = '0;
    bus.rcp_i = '0;
  endtask

  task automatic do_ref(input int sel, input int v);
    int k;
    bus.scal_sel_i = 3'(sel);
    k = cyc;
    expect_ev(EV_SCAL, k + 3, v);
    bus.ref_pulse_i = 1'b1;
    step(1);
    bus.ref_pulse_i = 1'b0;
    step(6);
  endtask

  initial begin : stim
    int k;
    ev_t e;
    bus.lcp_i       = '0;
    bus.rcp_i       = '0;
    bus.mask_i      = '0;
    bus.mode_i      = 2'b00;
    bus.window_i    = 4'd3;
    bus.ref_pulse_i = 1'b0;
    bus.scal_sel_i  = '0;
    step(3);
    check("reset trig_o", int'(bus.trig_o), 0);
    check("reset l2_o", int'(bus.l2_o), 0);
    check("reset scal_o", int'(bus.scal_o), 0);
    check("reset scal_valid_o", int'(bus.scal_valid_o), 0);
    rst_n = 1'b1;
    step(3);

    // AND coincidence, LCP then RCP two cycles later
    k = cyc;
    fire_exp(k, 1, 5);
    bus.lcp_i = 6'd1;
    step(1);
    bus.lcp_i = '0;
    step(1);
    bus.rcp_i = 6'd1;
    step(1);
    bus.rcp_i = '0;
    step(20);
    do_ref(0, 1);

    // RCP four cycles late: no AND, but OR fires from LCP
    bus.lcp_i = 6'd1;
    step(1);
    bus.lcp_i = '0;
    step(3);
    bus.rcp_i = 6'd1;
    step(1);
    bus.rcp_i = '0;
    step(25);
    do_ref(0, 0);
    bus.mode_i = 2'b01;
    k = cyc;
    fire_exp(k, 1, 3);
    bus.lcp_i = 6'd1;
    step(1);
    bus.lcp_i = '0;
    step(3);
    bus.rcp_i = 6'd1;
    step(1);
    bus.rcp_i = '0;
    step(25);
    do_ref(0, 1);
    bus.mode_i = 2'b00;

    // sector 2 rising every 5 cycles fires every 15, then masked
    k = cyc;
    for (int i = 0; i < 3; i++) fire_exp(k + 15 * i, 4, 3);
    for (int i = 0; i < 7; i++) begin
      pulse(6'd4, 6'd4);
      step(4);
    end
    step(20);
    do_ref(2, 3);
    bus.mask_i = 6'd4;
    for (int i = 0; i < 7; i++) begin
      pulse(6'd4, 6'd4);
      step(4);
    end
    step(20);
    do_ref(2, 0);
    bus.mask_i = '0;

    // L2: sectors 1 and 4 together, then sector 1 alone
    k = cyc;
    expect_ev(EV_RISE, k + 3, 'h12);
    expect_ev(EV_L2, k + 4, 1);
    expect_ev(EV_FALL, k + 7, 'h12);
    pulse(6'h12, 6'h12);
    step(25);
    k = cyc;
    fire_exp(k, 2, 3);
    pulse(6'd2, 6'd2);
    step(25);
    do_ref(1, 2);

    // LCP-only with window 0, then RCP-only mode
    bus.window_i = 4'd0;
    bus.mode_i   = 2'b10;
    k = cyc;
    fire_exp(k, 8, 3);
    pulse(6'd8, 6'd0);
    step(25);
    bus.mode_i = 2'b11;
    pulse(6'd8, 6'd0);
    step(25);
    k = cyc;
    fire_exp(k, 8, 3);
    pulse(6'd0, 6'd8);
    step(25);
    do_ref(3, 2);
    bus.window_i = 4'd3;
    bus.mode_i   = 2'b00;

    // scaler saturation at 15 after 20 fires
    k = cyc;
    for (int i = 0; i < 20; i++) fire_exp(k + 15 * i, 1, 3);
    for (int i = 0; i < 20; i++) begin
      pulse(6'd1, 6'd1);
      step(14);
    end
    step(10);
    do_ref(0, 15);

    // fire on the bank cycle belongs to the new period
    k = cyc;
    expect_ev(EV_RISE, k + 3, 1);
    expect_ev(EV_SCAL, k + 4, 0);
    expect_ev(EV_FALL, k + 7, 1);
    bus.lcp_i = 6'd1;
    bus.rcp_i = 6'd1;
    step(1);
    bus.lcp_i = '0;
    bus.rcp_i = '0;
    bus.ref_pulse_i = 1'b1;
    step(1);
    bus.ref_pulse_i = 1'b0;
    step(25);
    do_ref(0, 1);

    // out-of-range select reads 0; bank holds
    k = cyc;
    fire_exp(k, 1, 3);
    pulse(6'd1, 6'd1);
    step(20);
    do_ref(6, 0);
    bus.scal_sel_i = '0;
    step(2);
    check("scal_o bank hold", int'(bus.scal_o), 1);

    // asynchronous reset mid-FIRE
    k = cyc;
    expect_ev(EV_RISE, k + 3, 'h12);
    pulse(6'h12, 6'h12);
    step(2);
    #5;
    check("trig_o before reset", int'(bus.trig_o), 'h12);
    rst_n = 1'b0;
    #1;
    check("async reset trig_o", int'(bus.trig_o), 0);
    check("async reset l2_o", int'(bus.l2_o), 0);
    check("async reset scal_o", int'(bus.scal_o), 0);
    step(3);
    rst_n = 1'b1;
    step(2);
    k = cyc;
    fire_exp(k, 1, 3);
    pulse(6'd1, 6'd1);
    step(20);

    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing %s: got nothing, required cycle %0d value 'h%0h",
               e.kind.name(), e.cyc, e.val);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
